repair_alloc_ctrl: RTL and testbench

Block-level repair allocator and remap controller for the 64 KB main SRAM and 25-block spare SRAM. During BIST it captures failing addresses, removes duplicates at 128-byte block granularity and assigns each failing block a spare block. In mission mode it compares every access address against the repair table and steers the access to the spare array on a hit. It sits between the BIST FSM, which supplies failing addresses, and the main/spare SRAM chip-select muxing in the memory controller top.

---
 rtl/repair_alloc_ctrl.sv | 140 ++++++++++++++
 tb/tb_repair_alloc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/repair_alloc_ctrl.sv
// Spare-block repair allocator: captures BIST failing blocks into a spare table
// and steers mission accesses that hit a captured block onto the spare array.
module repair_entry_cmp #(
   parameter int TAG_W = 9
) (
   input  logic             valid_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [TAG_W-1:0] look_tag_i,
   input  logic [TAG_W-1:0] fail_tag_i,
   output logic             hit_o,
   output logic             fmatch_o
);
   assign hit_o    = valid_i & (tag_i == look_tag_i);
   assign fmatch_o = valid_i & (tag_i == fail_tag_i);
endmodule

module repair_alloc_ctrl #(
   parameter int ADDR_W    = 16,
   parameter int BLK_LSB   = 7,
   parameter int NUM_SPARE = 25,
   parameter int IDX_W     = 5
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 bist_en_i,
   input  logic                 bist_done_i,
   input  logic                 fail_valid_i,
   input  logic [ADDR_W-1:0]    fail_addr_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic                 csb_i,
   output logic                 repair_hit_o,
   output logic [NUM_SPARE-1:0] spare_csb_o,
   output logic [BLK_LSB-1:0]   spare_addr_o,
   output logic [IDX_W-1:0]     repair_cnt_o,
   output logic                 repair_ovf_o,
   output logic                 repair_ready_o
);
   localparam int TAG_W = ADDR_W - BLK_LSB;

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_READY} state_e;

   state_e                          state_q, state_d;
   logic                            bist_en_q;
   logic [NUM_SPARE-1:0]            valid_q, valid_d;
   logic [NUM_SPARE-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [IDX_W-1:0]                cnt_q, cnt_d;
   logic                            ovf_q, ovf_d;
   logic [NUM_SPARE-1:0]            hit, fmatch, hit_1h;
   logic [TAG_W-1:0]                look_tag, fail_tag;
   logic                            en_rise, full, alloc;
   logic                            unused_ok;

   assign look_tag  = addr_i[ADDR_W-1:BLK_LSB];
   assign fail_tag  = fail_addr_i[ADDR_W-1:BLK_LSB];
   assign unused_ok = ^fail_addr_i[BLK_LSB-1:0];
   assign en_rise   = bist_en_i & ~bist_en_q;
   assign full      = (cnt_q == IDX_W'(NUM_SPARE));

   for (genvar g = 0; g < NUM_SPARE; g++) begin : g_ent
      repair_entry_cmp #(.TAG_W(TAG_W)) u_cmp (
         .valid_i    (valid_q[g]),
         .tag_i      (tag_q[g]),
         .look_tag_i (look_tag),
         .fail_tag_i (fail_tag),
         .hit_o      (hit[g]),
         .fmatch_o   (fmatch[g])
      );
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      alloc   = 1'b0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (en_rise) begin
               state_d = ST_COLLECT;
               valid_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_COLLECT: begin
            if (!bist_en_i && !bist_done_i) begin
               state_d = ST_IDLE;
               valid_d = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else begin
               // A strobe coinciding with DONE is still captured on that edge.
               if (fail_valid_i && !(|fmatch)) begin
                  if (full) ovf_d = 1'b1;
                  else      alloc = 1'b1;
               end
               if (bist_done_i) state_d = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (alloc) begin
         for (int i = 0; i < NUM_SPARE; i++) begin
            if (cnt_q == IDX_W'(i)) begin
               valid_d[i] = 1'b1;
               tag_d[i]   = fail_tag;
            end
         end
         cnt_d = cnt_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         bist_en_q <= 1'b0;
         valid_q   <= '0;
         tag_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bist_en_q <= bist_en_i;
         valid_q   <= valid_d;
         tag_q     <= tag_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   // Tags are unique by construction; isolating the lowest set bit keeps the select one-hot regardless.
   assign hit_1h         = hit & (~hit + NUM_SPARE'(1));
   assign repair_ready_o = (state_q == ST_READY);
   assign repair_hit_o   = repair_ready_o & ~csb_i & (|hit);
   assign spare_csb_o    = ~(hit_1h & {NUM_SPARE{repair_hit_o}});
   assign spare_addr_o   = addr_i[BLK_LSB-1:0];
   assign repair_cnt_o   = cnt_q;
   assign repair_ovf_o   = ovf_q;
endmodule

// File: tb/tb_repair_alloc_ctrl.sv
// Randomized + directed bench for repair_alloc_ctrl against a queue-based table model.
module tb_repair_alloc_ctrl;
   localparam int NS = 25;

   logic          clk_i = 1'b0;
   logic          rstn_i, bist_en_i, bist_done_i, fail_valid_i, csb_i;
   logic [15:0]   fail_addr_i, addr_i;
   logic          repair_hit_o, repair_ovf_o, repair_ready_o;
   logic [NS-1:0] spare_csb_o;
   logic [6:0]    spare_addr_o;
   logic [4:0]    repair_cnt_o;

   repair_alloc_ctrl dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .bist_en_i(bist_en_i), .bist_done_i(bist_done_i),
      .fail_valid_i(fail_valid_i), .fail_addr_i(fail_addr_i), .addr_i(addr_i), .csb_i(csb_i),
      .repair_hit_o(repair_hit_o), .spare_csb_o(spare_csb_o), .spare_addr_o(spare_addr_o),
      .repair_cnt_o(repair_cnt_o), .repair_ovf_o(repair_ovf_o), .repair_ready_o(repair_ready_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0, n_bad = 0;

   // Model: ordered list of captured block tags; list position == spare index.
   int m_tags[$];
   bit m_en_q, m_col, m_rdy, m_ovf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_tags.delete();
      m_en_q = 0; m_col = 0; m_rdy = 0; m_ovf = 0;
   endtask

   task automatic m_capture(input int t);
      bit seen = 0;
      foreach (m_tags[i]) if (m_tags[i] == t) seen = 1;
      if (!seen) begin
         if (m_tags.size() < NS) m_tags.push_back(t);
         else m_ovf = 1;
      end
   endtask

   task automatic m_step();
      bit rise = bist_en_i && !m_en_q;
      if (m_col) begin
         if (!bist_en_i && !bist_done_i) begin
            m_col = 0; m_tags.delete(); m_ovf = 0;
         end else begin
            if (fail_valid_i) m_capture(int'(fail_addr_i[15:7]));
            if (bist_done_i) begin m_col = 0; m_rdy = 1; end
         end
      end else if (rise) begin
         m_col = 1; m_rdy = 0; m_tags.delete(); m_ovf = 0;
      end
      m_en_q = bist_en_i;
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (rstn_i) m_step();
      #1;
      fail_valid_i = 0;
      bist_done_i  = 0;
   endtask

   task automatic chk_out(input string nm);
      int idx;
      logic ehit;
      logic [NS-1:0] ecsb;
      #1;
      idx = -1;
      foreach (m_tags[i]) if (idx < 0 && m_tags[i] == int'(addr_i[15:7])) idx = i;
      ehit = m_rdy && !csb_i && (idx >= 0);
      ecsb = '1;
      if (ehit) ecsb[idx] = 1'b0;
      chk({nm, ".hit"},   repair_hit_o,   ehit);
      chk({nm, ".csb"},   spare_csb_o,    ecsb);
      chk({nm, ".saddr"}, spare_addr_o,   addr_i[6:0]);
      chk({nm, ".cnt"},   repair_cnt_o,   m_tags.size());
      chk({nm, ".ovf"},   repair_ovf_o,   m_ovf);
      chk({nm, ".rdy"},   repair_ready_o, m_rdy);
   endtask

   task automatic fail(input logic [15:0] a);
      fail_valid_i = 1; fail_addr_i = a;
      tick();
   endtask

   task automatic lookup(input string nm, input logic [15:0] a, input logic cs);
      addr_i = a; csb_i = cs;
      chk_out(nm);
      tick();
   endtask

   logic [NS-1:0] e_csb;

   initial begin
      rstn_i = 0; bist_en_i = 0; bist_done_i = 0; fail_valid_i = 0;
      fail_addr_i = '0; addr_i = 16'h1234; csb_i = 0;
      m_reset();
      #12;
      chk_out("reset");
      chk("reset.saddr34", spare_addr_o, 7'h34);
      e_csb = '1;
      chk("reset.csb_ones", spare_csb_o, e_csb);
      #3 rstn_i = 1;
      tick();

      // Basic session with a duplicate block
      bist_en_i = 1; tick();
      fail(16'h0085); fail(16'h00F0); fail(16'h4000);
      bist_done_i = 1; tick();
      bist_en_i = 0;
      chk_out("s1.done");
      chk("s1.cnt2", repair_cnt_o, 2);
      addr_i = 16'h00A1; csb_i = 0; #1;
      e_csb = ~(NS'(1));
      chk("s1.a1_csb", spare_csb_o, e_csb);
      chk("s1.a1_saddr", spare_addr_o, 7'h21);
      lookup("s1.a1", 16'h00A1, 0);
      lookup("s1.4005", 16'h4005, 0);
      lookup("s1.4005_csbhi", 16'h4005, 1);
      lookup("s1.0200", 16'h0200, 0);

      // Overflow: 26 distinct blocks
      bist_en_i = 1; tick();
      for (int t = 0; t < 26; t++) fail(16'(t << 7) | 16'($urandom_range(0, 127)));
      bist_done_i = 1; tick();
      bist_en_i = 0;
      chk_out("ovf.done");
      chk("ovf.cnt25", repair_cnt_o, 25);
      chk("ovf.flag", repair_ovf_o, 1);
      lookup("ovf.tag25", 16'(25 << 7), 0);
      addr_i = 16'(24 << 7) | 16'h11; #1;
      e_csb = ~(NS'(1) << 24);
      chk("ovf.tag24_csb", spare_csb_o, e_csb);
      lookup("ovf.tag24", 16'(24 << 7) | 16'h11, 0);

      // FAIL_VALID coincident with BIST_DONE
      bist_en_i = 1; tick();
      fail(16'(5 << 7));
      fail_valid_i = 1; fail_addr_i = 16'(9 << 7); bist_done_i = 1; tick();
      bist_en_i = 0;
      chk_out("same.done");
      chk("same.cnt2", repair_cnt_o, 2);
      lookup("same.tag9", 16'(9 << 7) | 16'h3, 0);

      // Abort mid-collection
      bist_en_i = 1; tick();
      fail(16'(3 << 7)); fail(16'(4 << 7));
      bist_en_i = 0; tick();
      chk_out("abort");
      chk("abort.cnt0", repair_cnt_o, 0);
      fail(16'(6 << 7));
      lookup("abort.ign", 16'(3 << 7), 0);

      // Async reset in READY with three entries
      bist_en_i = 1; tick();
      fail(16'(1 << 7)); fail(16'(2 << 7)); fail(16'(7 << 7));
      bist_done_i = 1; tick();
      bist_en_i = 0;
      chk_out("pre_rst");
      chk("pre_rst.cnt3", repair_cnt_o, 3);
      addr_i = 16'(2 << 7); csb_i = 0;
      #1 rstn_i = 0;
      m_reset();
      chk_out("arst");
      tick();
      rstn_i = 1;
      tick();
      bist_en_i = 1; tick();
      fail(16'(8 << 7));
      bist_done_i = 1; tick();
      bist_en_i = 0;
      chk("arst.new_cnt1", repair_cnt_o, 1);
      lookup("arst.old", 16'(2 << 7), 0);
      lookup("arst.new", 16'(8 << 7), 0);

      // Random sessions
      for (int s = 0; s < 8; s++) begin
         bit ended = 0;
         int pool = (s % 2) ? 40 : 12;
         bist_en_i = 1; tick();
         for (int c = 0; c < 70 && !ended; c++) begin
            fail_valid_i = 1'($urandom_range(0, 1));
            fail_addr_i  = 16'($urandom_range(0, pool - 1) << 7) | 16'($urandom_range(0, 127));
            addr_i = 16'($urandom); csb_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin bist_en_i = 0; ended = 1; end
            else if ($urandom_range(0, 29) == 0 || c == 69) begin bist_done_i = 1; ended = 1; end
            chk_out("rnd.col");
            tick();
         end
         bist_en_i = 0;
         for (int k = 0; k < 20; k++)
            lookup("rnd.look",
                   16'($urandom_range(0, pool + 3) << 7) | 16'($urandom_range(0, 127)),
                   1'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
